// File: rtl/pong_score_fsm.sv
// Pong match controller: wall hit/miss decisions, scores and match sequencing.
// Define WIN_BY_TWO_EN so that a match only ends once the scorer also leads by two points.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; ball held
// SERVE | ball held and re-centred for SERVE_TICKS cycles
// PLAY  | ball free; wall contacts decide hit or miss
// POINT | pause for POINT_TICKS cycles after a point is scored
// OVER  | match finished; scores frozen until a start rising edge
module pong_score_fsm #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 30,
    parameter int PADDLE_H    = 40
) (
    input  logic       game_clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] x_ball,
    input  logic [9:0] y_ball,
    input  logic [4:0] height_ball,
    input  logic [4:0] width_ball,
    input  logic [9:0] x_lwall,
    input  logic [9:0] x_rwall,
    input  logic [9:0] y_lpaddle,
    input  logic [9:0] y_rpaddle,
    output logic       ball_hold,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       hit_l,
    output logic       hit_r,
    output logic [2:0] state,
    output logic       winner
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int TMAX  = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int CNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] POINT_LD = CNT_W'(POINT_TICKS - 1);
    localparam logic [3:0]       WIN4     = 4'(WIN_SCORE);
    localparam logic [10:0]      PH11     = 11'(PADDLE_H);

    state_t           st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       score_l_nx, score_r_nx;
    logic             dir_nx, winner_nx, hit_l_nx, hit_r_nx;
    logic             win_pend, win_pend_nx;
    logic             cl_prev, cr_prev, start_prev;

    logic             cl, cr, ovl, ovr, cl_edge, cr_edge;
    logic [3:0]       l_inc, r_inc;
    logic             l_wins, r_wins;

    // 11-bit arithmetic so ball edge + size never wraps near the screen limit
    assign cl  = {1'b0, x_ball} <= {1'b0, x_lwall};
    assign cr  = ({1'b0, x_ball} + {6'b0, width_ball}) >= {1'b0, x_rwall};
    assign ovl = (({1'b0, y_ball} + {6'b0, height_ball}) > {1'b0, y_lpaddle}) &&
                 ({1'b0, y_ball} < ({1'b0, y_lpaddle} + PH11));
    assign ovr = (({1'b0, y_ball} + {6'b0, height_ball}) > {1'b0, y_rpaddle}) &&
                 ({1'b0, y_ball} < ({1'b0, y_rpaddle} + PH11));

    assign cl_edge = cl & ~cl_prev;
    assign cr_edge = cr & ~cr_prev;

    assign l_inc = (score_l == 4'hF) ? 4'hF : score_l + 4'd1;
    assign r_inc = (score_r == 4'hF) ? 4'hF : score_r + 4'd1;

    // Match outcome is decided when the point is scored, using pre-point scores,
    // so that a saturated 15-15 can still be told apart from a fresh 15-15.
`ifdef WIN_BY_TWO_EN
    assign l_wins = (l_inc >= WIN4) &&
                    (({1'b0, l_inc} >= ({1'b0, score_r} + 5'd2)) ||
                     (score_l == 4'hF && score_r == 4'hF));
    assign r_wins = (r_inc >= WIN4) &&
                    (({1'b0, r_inc} >= ({1'b0, score_l} + 5'd2)) ||
                     (score_l == 4'hF && score_r == 4'hF));
`else
    assign l_wins = l_inc >= WIN4;
    assign r_wins = r_inc >= WIN4;
`endif

    assign ball_hold = (st != S_PLAY);
    assign state     = st;

    always_ff @(posedge game_clk or negedge reset) begin
        if (!reset) begin
            st         <= S_IDLE;
            cnt        <= '0;
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            serve_dir  <= 1'b0;
            winner     <= 1'b0;
            hit_l      <= 1'b0;
            hit_r      <= 1'b0;
            win_pend   <= 1'b0;
            cl_prev    <= 1'b0;
            cr_prev    <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            st         <= st_nx;
            cnt        <= cnt_nx;
            score_l    <= score_l_nx;
            score_r    <= score_r_nx;
            serve_dir  <= dir_nx;
            winner     <= winner_nx;
            hit_l      <= hit_l_nx;
            hit_r      <= hit_r_nx;
            win_pend   <= win_pend_nx;
            cl_prev    <= cl;
            cr_prev    <= cr;
            start_prev <= start;
        end
    end

    always_comb begin
        st_nx       = st;
        cnt_nx      = cnt;
        score_l_nx  = score_l;
        score_r_nx  = score_r;
        dir_nx      = serve_dir;
        winner_nx   = winner;
        hit_l_nx    = 1'b0;
        hit_r_nx    = 1'b0;
        win_pend_nx = win_pend;
        case (st)
            S_IDLE: begin
                if (start) begin
                    st_nx  = S_SERVE;
                    cnt_nx = SERVE_LD;
                end
            end
            S_SERVE: begin
                if (cnt == '0) st_nx = S_PLAY;
                else           cnt_nx = cnt - CNT_W'(1);
            end
            S_PLAY: begin
                // left wall has priority when both contacts rise together
                if (cl_edge) begin
                    if (ovl) begin
                        hit_l_nx = 1'b1;
                    end else begin
                        score_r_nx  = r_inc;
                        dir_nx      = 1'b0;
                        win_pend_nx = r_wins;
                        st_nx       = S_POINT;
                        cnt_nx      = POINT_LD;
                    end
                end else if (cr_edge) begin
                    if (ovr) begin
                        hit_r_nx = 1'b1;
                    end else begin
                        score_l_nx  = l_inc;
                        dir_nx      = 1'b1;
                        win_pend_nx = l_wins;
                        st_nx       = S_POINT;
                        cnt_nx      = POINT_LD;
                    end
                end
            end
            S_POINT: begin
                if (cnt == '0) begin
                    if (win_pend) begin
                        st_nx     = S_OVER;
                        winner_nx = ~serve_dir;
                    end else begin
                        st_nx  = S_SERVE;
                        cnt_nx = SERVE_LD;
                    end
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_OVER: begin
                if (start && !start_prev) begin
                    score_l_nx  = 4'd0;
                    score_r_nx  = 4'd0;
                    win_pend_nx = 1'b0;
                    st_nx       = S_SERVE;
                    cnt_nx      = SERVE_LD;
                end
            end
            default: st_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pong_score_fsm.sv
// Directed bench for pong_score_fsm: wall decision table plus serve/point/win/reset sequences.
module tb_pong_score_fsm;

    localparam int WIN = 7;
    localparam int ST  = 60;
    localparam int PT  = 30;
    localparam int PH  = 40;

    logic       game_clk = 1'b0;
    logic       reset, start;
    logic [9:0] x_ball, y_ball, x_lwall, x_rwall, y_lpaddle, y_rpaddle;
    logic [4:0] height_ball, width_ball;
    logic       ball_hold, serve_dir, hit_l, hit_r, winner;
    logic [3:0] score_l, score_r;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int m_l = 0, m_r = 0, m_dir = 0;

    typedef struct {
        logic [9:0] xb, yb, ylp, yrp, xrw;
        logic [4:0] wb, hb;
        bit         e_hl, e_hr, miss_l, miss_r;
    } vec_t;

    vec_t vecs[12];

    always #5 game_clk = ~game_clk;

    pong_score_fsm #(.WIN_SCORE(WIN), .SERVE_TICKS(ST), .POINT_TICKS(PT), .PADDLE_H(PH)) dut (
        .game_clk(game_clk), .reset(reset), .start(start),
        .x_ball(x_ball), .y_ball(y_ball), .height_ball(height_ball), .width_ball(width_ball),
        .x_lwall(x_lwall), .x_rwall(x_rwall), .y_lpaddle(y_lpaddle), .y_rpaddle(y_rpaddle),
        .ball_hold(ball_hold), .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r),
        .hit_l(hit_l), .hit_r(hit_r), .state(state), .winner(winner)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge game_clk);
        #1;
    endtask

    task automatic neutral();
        x_ball = 10'd300; y_ball = 10'd200; width_ball = 5'd8; height_ball = 5'd8;
        x_lwall = 10'd10; x_rwall = 10'd600;
    endtask

    function automatic vec_t mk(int xb, int yb, int ylp, int yrp, int xrw, int wb, int hb,
                                bit hl, bit hr, bit ml, bit mr);
        vec_t v;
        v.xb = 10'(xb); v.yb = 10'(yb); v.ylp = 10'(ylp); v.yrp = 10'(yrp); v.xrw = 10'(xrw);
        v.wb = 5'(wb); v.hb = 5'(hb);
        v.e_hl = hl; v.e_hr = hr; v.miss_l = ml; v.miss_r = mr;
        return v;
    endfunction

    function automatic int sat_inc(int s);
        return (s >= 15) ? 15 : s + 1;
    endfunction

    function automatic bit exp_over(int s, int o);
        int nw;
        nw = sat_inc(s);
`ifdef WIN_BY_TWO_EN
        return (nw >= WIN) && ((nw >= o + 2) || (s == 15 && o == 15));
`else
        return nw >= WIN;
`endif
    endfunction

    task automatic chk_scores(input string nm);
        chk({nm, "_score_l"}, int'(score_l), m_l);
        chk({nm, "_score_r"}, int'(score_r), m_r);
    endtask

    task automatic wait_state(input int s, input string nm);
        int n;
        n = 0;
        while (int'(state) != s && n < 2000) begin
            n++;
            tick();
        end
        chk(nm, int'(state), s);
    endtask

    // Called on the first sample after a miss; walks POINT and (if no win) SERVE.
    task automatic finish_point(input bit over, input bit left_miss);
        int n;
        n = 0;
        while (state == 3'd3 && n < 1000) begin
            n++;
            tick();
        end
        chk("point_len", n, PT);
        if (over) begin
            chk("over_state", int'(state), 4);
            chk("winner", int'(winner), left_miss ? 1 : 0);
            chk("over_hold", int'(ball_hold), 1);
        end else begin
            n = 0;
            while (state == 3'd1 && ball_hold && n < 1000) begin
                n++;
                tick();
            end
            chk("serve_len", n, ST);
            chk("play_state", int'(state), 2);
            chk("play_hold", int'(ball_hold), 0);
        end
    endtask

    task automatic score_point(input bit left_miss);
        bit over;
        neutral();
        tick();
        if (left_miss) begin
            y_lpaddle = 10'd300; x_ball = 10'd10; y_ball = 10'd100;
            over = exp_over(m_r, m_l); m_r = sat_inc(m_r); m_dir = 0;
        end else begin
            y_rpaddle = 10'd300; x_ball = 10'd592; y_ball = 10'd100;
            over = exp_over(m_l, m_r); m_l = sat_inc(m_l); m_dir = 1;
        end
        tick();
        chk("miss_state", int'(state), 3);
        chk_scores("miss");
        chk("miss_dir", int'(serve_dir), m_dir);
        chk("miss_nohit", int'(hit_l | hit_r), 0);
        neutral();
        finish_point(over, left_miss);
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        bit   over;
        v = vecs[i];
        over = 1'b0;
        neutral();
        y_lpaddle = v.ylp; y_rpaddle = v.yrp;
        tick();
        x_ball = v.xb; y_ball = v.yb; x_rwall = v.xrw; width_ball = v.wb; height_ball = v.hb;
        if (v.miss_l) begin
            over = exp_over(m_r, m_l); m_r = sat_inc(m_r); m_dir = 0;
        end else if (v.miss_r) begin
            over = exp_over(m_l, m_r); m_l = sat_inc(m_l); m_dir = 1;
        end
        tick();
        chk($sformatf("vec%0d_hit_l", i), int'(hit_l), int'(v.e_hl));
        chk($sformatf("vec%0d_hit_r", i), int'(hit_r), int'(v.e_hr));
        chk($sformatf("vec%0d_state", i), int'(state), (v.miss_l || v.miss_r) ? 3 : 2);
        chk($sformatf("vec%0d_dir", i), int'(serve_dir), m_dir);
        chk_scores($sformatf("vec%0d", i));
        neutral();
        if (v.miss_l || v.miss_r) begin
            finish_point(over, v.miss_l);
        end else begin
            tick();
            chk($sformatf("vec%0d_pulse_end", i), int'(hit_l | hit_r), 0);
        end
    endtask

    initial begin
        int n;
        //            xb    yb   ylp   yrp   xrw  wb  hb  hl hr ml mr
        vecs[0]  = mk(10,   120, 100,  100,  600, 8,  8,  1, 0, 0, 0);
        vecs[1]  = mk(5,    140, 100,  100,  600, 8,  8,  0, 0, 1, 0);
        vecs[2]  = mk(10,   92,  100,  100,  600, 8,  8,  0, 0, 1, 0);
        vecs[3]  = mk(10,   93,  100,  100,  600, 8,  8,  1, 0, 0, 0);
        vecs[4]  = mk(592,  200, 100,  180,  600, 8,  8,  0, 1, 0, 0);
        vecs[5]  = mk(591,  200, 100,  180,  600, 8,  8,  0, 0, 0, 0);
        vecs[6]  = mk(592,  300, 100,  180,  600, 8,  8,  0, 0, 0, 1);
        vecs[7]  = mk(11,   120, 100,  100,  600, 8,  8,  0, 0, 0, 0);
        vecs[8]  = mk(10,   120, 100,  500,  41,  31, 8,  1, 0, 0, 0);
        vecs[9]  = mk(10,   120, 300,  100,  41,  31, 8,  0, 0, 1, 0);
        vecs[10] = mk(1000, 200, 100,  180,  1023, 31, 8, 0, 1, 0, 0);
        vecs[11] = mk(592,  1020, 100, 1000, 600, 8,  10, 0, 1, 0, 0);

        reset = 1'b0; start = 1'b0;
        neutral();
        y_lpaddle = 10'd100; y_rpaddle = 10'd100;
        repeat (3) @(posedge game_clk);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_hold", int'(ball_hold), 1);
        chk("rst_dir", int'(serve_dir), 0);
        chk("rst_hits", int'(hit_l | hit_r), 0);
        chk("rst_winner", int'(winner), 0);
        chk_scores("rst");

        reset = 1'b1; start = 1'b1;
        tick();
        chk("start_state", int'(state), 1);
        n = 0;
        while (state == 3'd1 && ball_hold && n < 1000) begin
            n++;
            tick();
        end
        chk("first_serve_len", n, ST);
        chk("first_play", int'(state), 2);
        chk("first_play_hold", int'(ball_hold), 0);
        start = 1'b0;

        // sustained contact: one pulse only
        neutral(); y_lpaddle = 10'd100;
        tick();
        x_ball = 10'd10; y_ball = 10'd120;
        tick();
        chk("sustain_first_pulse", int'(hit_l), 1);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (hit_l) n++;
        end
        chk("sustain_extra_pulses", n, 0);
        chk("sustain_state", int'(state), 2);
        chk_scores("sustain");

        for (int i = 0; i < 12; i++) apply_vec(i);

        // right misses until left reaches WIN; start held high across OVER entry
        start = 1'b1;
        while (m_l < WIN - 1) score_point(1'b0);
        score_point(1'b0);
        repeat (3) tick();
        chk("over_hold_start", int'(state), 4);
        chk("over_winner", int'(winner), 0);
        chk_scores("over_frozen");
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        m_l = 0; m_r = 0;
        chk("restart_state", int'(state), 1);
        chk_scores("restart");
        wait_state(2, "restart_play");

        score_point(1'b0); score_point(1'b0); score_point(1'b0);
        score_point(1'b1); score_point(1'b1);
        chk_scores("pre_reset");

        reset = 1'b0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_score_l", int'(score_l), 0);
        chk("async_score_r", int'(score_r), 0);
        chk("async_hold", int'(ball_hold), 1);
        m_l = 0; m_r = 0; m_dir = 0;
        repeat (2) tick();
        reset = 1'b1;

`ifdef WIN_BY_TWO_EN
        wait_state(2, "w2_play");
        for (int k = 0; k < 6; k++) begin
            score_point(1'b0);
            score_point(1'b1);
        end
        score_point(1'b0);
        chk("w2_7_6_continue", int'(state), 2);
        score_point(1'b0);
        chk("w2_8_6_over", int'(state), 4);
        chk_scores("w2_final");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
